// File: rtl/ysyx_22040895_mem_arbiter_pkg.sv
// ysyx_22040895_mem_pkg: shared widths, FSM/grant encodings and IFU fetch mask for the memory arbiter
package ysyx_22040895_mem_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int MASK_W = DATA_W / 8;

    // Fetches are always 32-bit instruction reads
    localparam logic [MASK_W-1:0] IFU_WMASK = MASK_W'(8'h0F);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
    typedef enum logic {GNT_IFU, GNT_LSU} grant_e;

endpackage

// File: rtl/ysyx_22040895_mem_arbiter_if.sv
// ysyx_22040895_mem_arbiter_if: IFU, LSU and memory-side handshake bundle; slave = arbiter view, master = environment view
interface ysyx_22040895_mem_arbiter_if;
    import ysyx_22040895_mem_pkg::*;

    logic              ifu_req_valid;
    logic              ifu_req_ready;
    logic [ADDR_W-1:0] ifu_req_addr;
    logic              ifu_resp_valid;
    logic [DATA_W-1:0] ifu_resp_data;

    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [ADDR_W-1:0] lsu_req_addr;
    logic              lsu_req_we;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic [MASK_W-1:0] lsu_req_wmask;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_rdata;

    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_we;
    logic [DATA_W-1:0] mem_req_wdata;
    logic [MASK_W-1:0] mem_req_wmask;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_rdata;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        output mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_we, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_rdata,
        input  mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_rdata
    );

endinterface

// File: rtl/ysyx_22040895_mem_arbiter_pick.sv
// ysyx_22040895_arb_pick: 2-way grant picker; YSYX_22040895_ARB_RR_EN selects round-robin, else LSU-first fixed priority
module ysyx_22040895_arb_pick
    import ysyx_22040895_mem_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  grant_e last_grant,
    output grant_e grant
);

`ifdef YSYX_22040895_ARB_RR_EN
    // On contention serve whoever was not served last; a lone requester always wins
    always_comb begin
        grant = (ifu_valid && lsu_valid) ? ((last_grant == GNT_IFU) ? GNT_LSU : GNT_IFU)
                                         : (lsu_valid ? GNT_LSU : GNT_IFU);
    end
`else
    logic unused_last;
    assign unused_last = last_grant;

    // LSU always wins contention so loads/stores are never starved by fetches
    always_comb begin
        grant = lsu_valid ? GNT_LSU : GNT_IFU;
    end
`endif

endmodule

// File: rtl/ysyx_22040895_mem_arbiter.sv
// ysyx_22040895_mem_arbiter: shares one memory port between IFU and LSU via IDLE->REQ->WAIT; policy macro YSYX_22040895_ARB_RR_EN
module ysyx_22040895_mem_arbiter
    import ysyx_22040895_mem_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    ysyx_22040895_mem_arbiter_if.slave  bus,
    output logic                        busy,
    output logic                        err_spurious
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_WAIT = WAIT;

    logic [1:0]        state;
    grant_e            grant;
    grant_e            last_grant;
    grant_e            pick;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;
    logic              accept;
    logic              done;
    logic              ifu_hit;
    logic              lsu_hit;

    ysyx_22040895_arb_pick u_pick (
        .ifu_valid  (bus.ifu_req_valid),
        .lsu_valid  (bus.lsu_req_valid),
        .last_grant (last_grant),
        .grant      (pick)
    );

    assign accept  = (state == S_IDLE) && (bus.ifu_req_valid || bus.lsu_req_valid);
    assign done    = (state == S_WAIT) && bus.mem_resp_valid;
    assign ifu_hit = done && (grant == GNT_IFU);
    assign lsu_hit = done && (grant == GNT_LSU);

    // Handshakes and response routing are combinational; memory fields come straight from the latch
    always_comb begin
        bus.ifu_req_ready  = accept && (pick == GNT_IFU);
        bus.lsu_req_ready  = accept && (pick == GNT_LSU);
        bus.mem_req_valid  = state == S_REQ;
        bus.mem_req_addr   = addr_q;
        bus.mem_req_we     = we_q;
        bus.mem_req_wdata  = wdata_q;
        bus.mem_req_wmask  = wmask_q;
        bus.ifu_resp_valid = ifu_hit;
        bus.ifu_resp_data  = ifu_hit ? bus.mem_resp_rdata : '0;
        bus.lsu_resp_valid = lsu_hit;
        bus.lsu_resp_rdata = (lsu_hit && !we_q) ? bus.mem_resp_rdata : '0;
        busy               = state != S_IDLE;
    end

    // FSM plus request latch; fields load only on accept so they stay stable through REQ
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            grant      <= GNT_IFU;
            last_grant <= GNT_IFU;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    state   <= S_REQ;
                    grant   <= pick;
                    addr_q  <= (pick == GNT_LSU) ? bus.lsu_req_addr  : bus.ifu_req_addr;
                    we_q    <= (pick == GNT_LSU) ? bus.lsu_req_we    : 1'b0;
                    wdata_q <= (pick == GNT_LSU) ? bus.lsu_req_wdata : '0;
                    wmask_q <= (pick == GNT_LSU) ? bus.lsu_req_wmask : IFU_WMASK;
                end
                S_REQ: if (bus.mem_req_ready) state <= S_WAIT;
                S_WAIT: if (bus.mem_resp_valid) begin
                    state      <= S_IDLE;
                    last_grant <= grant;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // A response outside WAIT (including alongside the REQ accept) is dropped and remembered until reset
    always_ff @(posedge clk) begin
        if (rst) err_spurious <= 1'b0;
        else if (bus.mem_resp_valid && state != S_WAIT) err_spurious <= 1'b1;
    end

endmodule

// File: tb/tb_ysyx_22040895_mem_arbiter.sv
// tb_ysyx_22040895_mem_arbiter: scoreboard bench with a bench-side memory model for the IFU/LSU memory arbiter
module tb_ysyx_22040895_mem_arbiter;

    typedef struct {
        bit          lsu;
        logic [63:0] data;
    } exp_t;

    logic clk;
    logic rst;
    logic busy;
    logic err_spurious;

    int   tests;
    int   fails;
    exp_t exp_q[$];

    int   mem_hold;
    bit   mem_early;
    bit   spur;

    ysyx_22040895_mem_arbiter_if bus ();

    ysyx_22040895_mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .busy         (busy),
        .err_spurious (err_spurious)
    );

    function automatic logic [63:0] mem_fn(input logic [63:0] a);
        return (a == 64'h8000_0000) ? 64'h0000_0413 : {~a[31:0], a[31:0]};
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim time expired want finish before it");
        $fatal(1, "watchdog");
    end

    // Memory model: accepts after mem_hold stalled cycles, answers one cycle later (or in the same cycle if mem_early)
    initial begin
        int          cnt;
        bit          pend;
        logic [63:0] paddr;
        cnt = 0;
        pend = 0;
        paddr = 0;
        bus.mem_req_ready = 0;
        bus.mem_resp_valid = 0;
        bus.mem_resp_rdata = 0;
        forever begin
            @(negedge clk);
            bus.mem_req_ready = 0;
            bus.mem_resp_valid = 0;
            bus.mem_resp_rdata = 0;
            if (rst) begin
                cnt = 0;
                pend = 0;
            end else if (spur) begin
                bus.mem_resp_valid = 1;
                bus.mem_resp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                spur = 0;
            end else if (pend) begin
                bus.mem_resp_valid = 1;
                bus.mem_resp_rdata = mem_fn(paddr);
                pend = 0;
            end else if (bus.mem_req_valid) begin
                if (cnt < mem_hold) cnt++;
                else begin
                    cnt = 0;
                    paddr = bus.mem_req_addr;
                    bus.mem_req_ready = 1;
                    if (mem_early) begin
                        bus.mem_resp_valid = 1;
                        bus.mem_resp_rdata = mem_fn(paddr);
                    end else pend = 1;
                end
            end
        end
    end

    // Scoreboard: every response pulse must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.ifu_resp_valid || bus.lsu_resp_valid) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_unexpected got ifu=%0b lsu=%0b want no response", bus.ifu_resp_valid, bus.lsu_resp_valid);
                end else begin
                    exp_t        e;
                    logic [63:0] got;
                    e = exp_q.pop_front();
                    got = bus.lsu_resp_valid ? bus.lsu_resp_rdata : bus.ifu_resp_data;
                    if ((bus.ifu_resp_valid && bus.lsu_resp_valid) || bus.lsu_resp_valid !== e.lsu || got !== e.data) begin
                        fails++;
                        $display("FAIL sb_resp got lsu=%0b ifu=%0b data=%h want lsu=%0b data=%h",
                                 bus.lsu_resp_valid, bus.ifu_resp_valid, got, e.lsu, e.data);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        tests++;
        if (busy || exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_idle_timeout got busy=%0b pending=%0d want idle with 0 pending", name, busy, exp_q.size());
        end
    endtask

    task automatic drive_reqs(input bit iv, input logic [63:0] ia, input bit lv, input bit lwe,
                              input logic [63:0] la, input logic [63:0] lwd, input logic [7:0] lm,
                              output int first);
        bit ip;
        bit lp;
        int n;
        ip = iv;
        lp = lv;
        n = 0;
        first = -1;
        @(negedge clk);
        bus.ifu_req_addr = ia;
        bus.lsu_req_addr = la;
        bus.lsu_req_we = lwe;
        bus.lsu_req_wdata = lwd;
        bus.lsu_req_wmask = lm;
        bus.ifu_req_valid = ip;
        bus.lsu_req_valid = lp;
        while ((ip || lp) && n < 50) begin
            #1;
            tests++;
            if ((bus.ifu_req_ready && bus.lsu_req_ready) || (!ip && bus.ifu_req_ready) || (!lp && bus.lsu_req_ready)) begin
                fails++;
                $display("FAIL ready_legal got ifu=%0b lsu=%0b want at most the one valid requester", bus.ifu_req_ready, bus.lsu_req_ready);
            end
            if (ip && bus.ifu_req_ready) begin
                ip = 0;
                exp_q.push_back('{1'b0, mem_fn(ia)});
                if (first < 0) first = 0;
            end else if (lp && bus.lsu_req_ready) begin
                lp = 0;
                exp_q.push_back('{1'b1, lwe ? 64'h0 : mem_fn(la)});
                if (first < 0) first = 1;
            end
            @(negedge clk);
            bus.ifu_req_valid = ip;
            bus.lsu_req_valid = lp;
            n++;
        end
        tests++;
        if (ip || lp) begin
            fails++;
            $display("FAIL accept_timeout got pending ifu=%0b lsu=%0b want none", ip, lp);
        end
        bus.ifu_req_valid = 0;
        bus.lsu_req_valid = 0;
        wait_idle("drive");
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests++; if (err_spurious !== 1'b0) begin fails++; $display("FAIL reset_err got %0b want 0", err_spurious); end
        tests++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_mem_valid got %0b want 0", bus.mem_req_valid); end
        tests++;
        if ({bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata, bus.mem_req_wmask} !== 137'h0) begin
            fails++;
            $display("FAIL reset_mem_fields got addr=%h we=%0b wdata=%h wmask=%h want all 0",
                     bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata, bus.mem_req_wmask);
        end
        tests++;
        if ({bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid} !== 4'b0) begin
            fails++;
            $display("FAIL reset_handshake got rdy=%0b%0b resp=%0b%0b want 0000",
                     bus.ifu_req_ready, bus.lsu_req_ready, bus.ifu_resp_valid, bus.lsu_resp_valid);
        end
        @(negedge clk);
        rst = 0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_release_busy got %0b want 0", busy); end
    endtask

    task automatic test_ifu_only();
        @(negedge clk);
        bus.ifu_req_valid = 1;
        bus.ifu_req_addr = 64'h8000_0000;
        #1;
        tests++;
        if (bus.ifu_req_ready !== 1'b1 || bus.lsu_req_ready !== 1'b0) begin
            fails++;
            $display("FAIL ifu_accept got ifu_rdy=%0b lsu_rdy=%0b want 1 0", bus.ifu_req_ready, bus.lsu_req_ready);
        end
        exp_q.push_back('{1'b0, 64'h0000_0413});
        @(negedge clk);
        bus.ifu_req_valid = 0;
        #1;
        tests++;
        if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata, bus.mem_req_wmask, busy}
            !== {1'b1, 64'h8000_0000, 1'b0, 64'h0, 8'h0F, 1'b1}) begin
            fails++;
            $display("FAIL ifu_mem_req got v=%0b addr=%h we=%0b wdata=%h wmask=%h busy=%0b want 1 80000000 0 0 0f 1",
                     bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata, bus.mem_req_wmask, busy);
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.ifu_resp_valid !== 1'b1 || bus.ifu_resp_data !== 64'h413 || bus.lsu_resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL ifu_resp got v=%0b data=%h lsu_v=%0b mem_v=%0b want 1 413 0 0",
                     bus.ifu_resp_valid, bus.ifu_resp_data, bus.lsu_resp_valid, bus.mem_req_valid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || bus.ifu_resp_valid !== 1'b0 || bus.ifu_resp_data !== 64'h0) begin
            fails++;
            $display("FAIL ifu_done got busy=%0b resp_v=%0b data=%h want 0 0 0", busy, bus.ifu_resp_valid, bus.ifu_resp_data);
        end
    endtask

    task automatic test_contention();
        int f;
        int want;
        drive_reqs(1, 64'h8000_0040, 1, 0, 64'h8000_1000, 64'h0, 8'hFF, f);
        tests++; if (f !== 1) begin fails++; $display("FAIL contention1_first got %0d want 1", f); end
        drive_reqs(1, 64'h8000_0044, 1, 0, 64'h8000_1000, 64'h0, 8'hFF, f);
        tests++; if (f !== 1) begin fails++; $display("FAIL contention2_first got %0d want 1", f); end
        drive_reqs(0, 64'h0, 1, 0, 64'h8000_1008, 64'h0, 8'h03, f);
        tests++; if (f !== 1) begin fails++; $display("FAIL lsu_alone_first got %0d want 1", f); end
`ifdef YSYX_22040895_ARB_RR_EN
        want = 0;
`else
        want = 1;
`endif
        drive_reqs(1, 64'h8000_0048, 1, 0, 64'h8000_1010, 64'h0, 8'hFF, f);
        tests++; if (f !== want) begin fails++; $display("FAIL contention3_first got %0d want %0d", f, want); end
    endtask

    task automatic test_store_stall();
        mem_hold = 3;
        @(negedge clk);
        bus.lsu_req_valid = 1;
        bus.lsu_req_we = 1;
        bus.lsu_req_addr = 64'h8000_2008;
        bus.lsu_req_wdata = 64'hDEAD_BEEF;
        bus.lsu_req_wmask = 8'h0F;
        #1;
        tests++; if (bus.lsu_req_ready !== 1'b1) begin fails++; $display("FAIL store_accept got %0b want 1", bus.lsu_req_ready); end
        exp_q.push_back('{1'b1, 64'h0});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) bus.lsu_req_valid = 0;
            #1;
            tests++;
            if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata, bus.mem_req_wmask}
                !== {1'b1, 64'h8000_2008, 1'b1, 64'hDEAD_BEEF, 8'h0F}) begin
                fails++;
                $display("FAIL store_hold_%0d got v=%0b addr=%h we=%0b wdata=%h wmask=%h want 1 80002008 1 deadbeef 0f",
                         i, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_we, bus.mem_req_wdata, bus.mem_req_wmask);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.mem_req_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b1 || bus.lsu_resp_rdata !== 64'h0) begin
            fails++;
            $display("FAIL store_ack got mem_v=%0b resp_v=%0b rdata=%h want 0 1 0", bus.mem_req_valid, bus.lsu_resp_valid, bus.lsu_resp_rdata);
        end
        @(negedge clk);
        #1;
        tests++;
        if (bus.lsu_resp_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL store_done got resp_v=%0b busy=%0b want 0 0", bus.lsu_resp_valid, busy);
        end
        mem_hold = 0;
    endtask

    task automatic test_reset_mid();
        mem_early = 1;
        @(negedge clk);
        bus.ifu_req_valid = 1;
        bus.ifu_req_addr = 64'h8000_0100;
        #1;
        tests++; if (bus.ifu_req_ready !== 1'b1) begin fails++; $display("FAIL early_accept got %0b want 1", bus.ifu_req_ready); end
        @(negedge clk);
        bus.ifu_req_valid = 0;
        #1;
        tests++;
        if (bus.mem_req_valid !== 1'b1 || bus.ifu_resp_valid !== 1'b0 || bus.lsu_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_resp_dropped got mem_v=%0b ifu_resp=%0b lsu_resp=%0b want 1 0 0",
                     bus.mem_req_valid, bus.ifu_resp_valid, bus.lsu_resp_valid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (busy !== 1'b1 || err_spurious !== 1'b1 || bus.mem_req_valid !== 1'b0 || bus.ifu_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL early_wait got busy=%0b err=%0b mem_v=%0b resp=%0b want 1 1 0 0",
                     busy, err_spurious, bus.mem_req_valid, bus.ifu_resp_valid);
        end
        @(negedge clk);
        rst = 1;
        #1;
        tests++; if (bus.ifu_resp_valid !== 1'b0) begin fails++; $display("FAIL rst_wait_resp got %0b want 0", bus.ifu_resp_valid); end
        @(negedge clk);
        rst = 0;
        mem_early = 0;
        #1;
        tests++;
        if (busy !== 1'b0 || err_spurious !== 1'b0 || bus.mem_req_addr !== 64'h0 || bus.ifu_resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid got busy=%0b err=%0b addr=%h resp=%0b want 0 0 0 0",
                     busy, err_spurious, bus.mem_req_addr, bus.ifu_resp_valid);
        end
        @(negedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_stay got busy=%0b want 0", busy); end
    endtask

    task automatic test_spurious();
        int f;
        @(negedge clk);
        #1;
        tests++; if (err_spurious !== 1'b0) begin fails++; $display("FAIL spur_pre got err=%0b want 0", err_spurious); end
        spur = 1;
        @(negedge clk);
        #1;
        tests++;
        if ({bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_data, bus.lsu_resp_rdata} !== 130'h0) begin
            fails++;
            $display("FAIL spur_routed got ifu_v=%0b lsu_v=%0b ifu_d=%h lsu_d=%h want all 0",
                     bus.ifu_resp_valid, bus.lsu_resp_valid, bus.ifu_resp_data, bus.lsu_resp_rdata);
        end
        @(negedge clk);
        #1;
        tests++; if (err_spurious !== 1'b1) begin fails++; $display("FAIL spur_flag got err=%0b want 1", err_spurious); end
        drive_reqs(1, 64'h8000_0200, 0, 0, 64'h0, 64'h0, 8'h0, f);
        tests++; if (err_spurious !== 1'b1) begin fails++; $display("FAIL spur_sticky got err=%0b want 1", err_spurious); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1;
        bus.ifu_req_valid = 0;
        bus.ifu_req_addr = 0;
        bus.lsu_req_valid = 0;
        bus.lsu_req_addr = 0;
        bus.lsu_req_we = 0;
        bus.lsu_req_wdata = 0;
        bus.lsu_req_wmask = 0;
        test_reset();
        test_ifu_only();
        test_contention();
        test_store_stall();
        test_reset_mid();
        test_spurious();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover got %0d outstanding want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
